// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, the ARP w0 header layout and the ARP RX parser state encoding.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
  localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY   = 16'd2;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'd1;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned USER_W = 80;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned IP_W   = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 3;

  typedef struct packed {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] op;
  } arp_w0_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAD,
    ST_DROP,
    ST_DONE
  } arp_state_e;

endpackage

// File: rtl/arp_rx_parser.sv
// Receive-side ARP parser: validates the ARP header, learns the sender MAC/IP and
// raises a reply trigger for requests that target the local IP.
module arp_rx_parser
  import eth_pkg::*;
#(
  parameter logic [31:0] P_SRC_IP_ADDR = {8'd192, 8'd168, 8'd100, 8'd99}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [IP_W-1:0]   i_dymanic_src_ip,
  input  logic              i_src_ip_valid,
  input  logic [DATA_W-1:0] s_axis_arp_data,
  input  logic [USER_W-1:0] s_axis_arp_user,
  input  logic [7:0]        s_axis_arp_keep,
  input  logic              s_axis_arp_last,
  input  logic              s_axis_arp_valid,
  output logic              s_axis_arp_ready,
  output logic [MAC_W-1:0]  o_recv_target_mac,
  output logic [IP_W-1:0]   o_recv_target_ip,
  output logic              o_recv_target_valid,
  output logic              o_arp_reply,
  output logic [CNT_W-1:0]  o_arp_drop_cnt
);

  arp_state_e        state, next_state;
  logic [WORD_W-1:0] r_word;
  logic [IP_W-1:0]   local_ip;
  logic [MAC_W-1:0]  sha_r;
  logic [IP_W-1:0]   spa_r;
  logic              req_r;
  logic              match_r;

  logic    beat_c, w0_ok_c, tpa_match_c;
  logic    drop_c, done_c, cap_w0_c, cap_w1_c, cap_w2_c, cap_w3_c;
  arp_w0_t w0_c;
  logic    unused_c;

  assign unused_c    = ^{s_axis_arp_keep, s_axis_arp_user[USER_W-1:16]};
  assign beat_c      = s_axis_arp_valid & s_axis_arp_ready;
  assign w0_c        = arp_w0_t'(s_axis_arp_data);
  assign w0_ok_c     = (s_axis_arp_user[15:0] == ETH_TYPE_ARP) &&
                       (w0_c.htype == ARP_HTYPE_ETH) && (w0_c.ptype == ETH_TYPE_IPV4) &&
                       (w0_c.hlen == ARP_HLEN_ETH) && (w0_c.plen == ARP_PLEN_IPV4) &&
                       ((w0_c.op == ARP_OP_REQUEST) || (w0_c.op == ARP_OP_REPLY));
  // When w3 carries last, the match is resolved in the same cycle the strobes are loaded.
  assign tpa_match_c = cap_w3_c ? (s_axis_arp_data[63:32] == local_ip) : match_r;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state and per-beat capture/decision strobes
  always_comb begin
    next_state = state;
    drop_c     = 1'b0;
    done_c     = 1'b0;
    cap_w0_c   = 1'b0;
    cap_w1_c   = 1'b0;
    cap_w2_c   = 1'b0;
    cap_w3_c   = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (state == ST_DONE) next_state = ST_IDLE;
        if (beat_c) begin
          if (s_axis_arp_last) begin
            next_state = ST_IDLE;
            drop_c     = 1'b1;
          end else if (w0_ok_c) begin
            next_state = ST_HDR;
            cap_w0_c   = 1'b1;
          end else begin
            next_state = ST_DROP;
          end
        end
      end
      ST_HDR: begin
        if (beat_c) begin
          if (r_word == WORD_W'(1) || r_word == WORD_W'(2)) begin
            cap_w1_c = (r_word == WORD_W'(1));
            cap_w2_c = (r_word == WORD_W'(2));
            if (s_axis_arp_last) begin
              next_state = ST_IDLE;
              drop_c     = 1'b1;
            end
          end else begin
            cap_w3_c   = 1'b1;
            next_state = s_axis_arp_last ? ST_DONE : ST_PAD;
            done_c     = s_axis_arp_last;
          end
        end
      end
      ST_PAD: begin
        if (beat_c && s_axis_arp_last) begin
          next_state = ST_DONE;
          done_c     = 1'b1;
        end
      end
      ST_DROP: begin
        if (beat_c && s_axis_arp_last) begin
          next_state = ST_IDLE;
          drop_c     = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Beat counter, field capture, local IP, outputs and drop counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word              <= '0;
      local_ip            <= P_SRC_IP_ADDR;
      sha_r               <= '0;
      spa_r               <= '0;
      req_r               <= 1'b0;
      match_r             <= 1'b0;
      s_axis_arp_ready    <= 1'b0;
      o_recv_target_mac   <= '0;
      o_recv_target_ip    <= '0;
      o_recv_target_valid <= 1'b0;
      o_arp_reply         <= 1'b0;
      o_arp_drop_cnt      <= '0;
    end else begin
      s_axis_arp_ready <= 1'b1;
      if (beat_c) begin
        if (s_axis_arp_last)               r_word <= '0;
        else if (r_word != WORD_W'(7))     r_word <= r_word + WORD_W'(1);
      end
      if (i_src_ip_valid) local_ip <= i_dymanic_src_ip;
      if (cap_w0_c) req_r <= (w0_c.op == ARP_OP_REQUEST);
      if (cap_w1_c) begin
        sha_r        <= s_axis_arp_data[63:16];
        spa_r[31:16] <= s_axis_arp_data[15:0];
      end
      if (cap_w2_c) spa_r[15:0] <= s_axis_arp_data[63:48];
      if (cap_w3_c) match_r <= tpa_match_c;
      o_recv_target_valid <= done_c;
      o_arp_reply         <= done_c & req_r & tpa_match_c;
      if (done_c) begin
        o_recv_target_mac <= sha_r;
        o_recv_target_ip  <= spa_r;
      end
      if (drop_c && o_arp_drop_cnt != 16'hFFFF) o_arp_drop_cnt <= o_arp_drop_cnt + CNT_W'(1);
    end
  end

endmodule
